// File: rtl/mem_arb_ctrl_pkg.sv
// Shared types and constants for the memory arbiter / pipeline sequencer.
// State encodings, stall-vector layout and the default access timeout.
package mem_arb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_ACC  = 2'd1,
        ST_MEM_ACC = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRV_IF  = 1'b0,
        SRV_MEM = 1'b1
    } served_e;

    localparam logic StallNo  = 1'b0;
    localparam logic StallYes = 1'b1;

    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IF_ID  = 1;
    localparam int unsigned STALL_ID_EX  = 2;
    localparam int unsigned STALL_EX_MEM = 3;
    localparam int unsigned STALL_MEM_WB = 4;
    localparam int unsigned STALL_WB     = 5;
    localparam int unsigned STALL_W      = STALL_WB + 1;

    // Holds every stage from the PC up to and including stage 'top'.
    function automatic logic [STALL_W-1:0] stall_upto(input int unsigned top);
        logic [STALL_W-1:0] s;
        for (int unsigned i = 0; i < STALL_W; i++) begin
            s[i] = (i <= top) ? StallYes : StallNo;
        end
        return s;
    endfunction

    localparam logic [STALL_W-1:0] STALL_MEM  = stall_upto(STALL_MEM_WB);
    localparam logic [STALL_W-1:0] STALL_EX   = stall_upto(STALL_EX_MEM);
    localparam logic [STALL_W-1:0] STALL_ID   = stall_upto(STALL_ID_EX);
    localparam logic [STALL_W-1:0] STALL_IF   = stall_upto(STALL_IF_ID);
    localparam logic [STALL_W-1:0] STALL_NONE = '0;

    localparam int unsigned MAX_WAIT_DEF = 15;

endpackage

// File: rtl/mem_arb_ctrl_stall_gen.sv
// Combinational priority encoder that merges all hold requests into the
// pipeline stall vector; the oldest blocked stage wins.
module mem_arb_ctrl_stall_gen
    import mem_arb_ctrl_pkg::*;
(
    input  logic               mem_pending_i,
    input  logic               stallreq_ex_i,
    input  logic               stallreq_id_i,
    input  logic               if_pending_i,
    output logic [STALL_W-1:0] stall_o
);

    always_comb begin
        if (mem_pending_i) begin
            stall_o = STALL_MEM;
        end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end else if (if_pending_i) begin
            stall_o = STALL_IF;
        end else begin
            stall_o = STALL_NONE;
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Shared memory-port arbiter between fetch and load/store, with bus timeout,
// and the single source of the pipeline stall vector.
module mem_arb_ctrl
    import mem_arb_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic [DATA_W-1:0]  if_rdata_o,
    output logic               if_ready_o,

    input  logic               mem_req_i,
    input  logic               mem_we_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [3:0]         mem_sel_i,
    output logic [DATA_W-1:0]  mem_rdata_o,
    output logic               mem_ready_o,

    output logic               bus_req_o,
    output logic               bus_we_o,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic [DATA_W-1:0]  bus_wdata_o,
    output logic [3:0]         bus_sel_o,
    input  logic               bus_ack_i,
    input  logic [DATA_W-1:0]  bus_rdata_i,

    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               bus_err_o
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    served_e           served_q, served_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        cnt_inc;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              bus_err_q, bus_err_d;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        served_d    = served_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    state_d     = ST_MEM_ACC;
                    served_d    = SRV_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    bus_sel_d   = mem_sel_i;
                end else if (if_req_i) begin
                    state_d     = ST_IF_ACC;
                    served_d    = SRV_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    bus_sel_d   = 4'b1111;
                end
            end

            ST_IF_ACC, ST_MEM_ACC: begin
                // Ack is tested first so a late ack still completes normally.
                if (bus_ack_i || cnt_inc == MAX_WAIT_C) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    bus_req_d = 1'b0;
                    bus_err_d = !bus_ack_i;
                    if (state_q == ST_MEM_ACC) begin
                        mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus_ack_i ? bus_rdata_i : '0;
                        if_ready_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            served_q    <= SRV_IF;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_err_o   = bus_err_q;

    // A request stops stalling in the DONE cycle that answers it.
    logic done_mem, done_if;
    assign done_mem = (state_q == ST_DONE) && (served_q == SRV_MEM);
    assign done_if  = (state_q == ST_DONE) && (served_q == SRV_IF);

    mem_arb_ctrl_stall_gen u_stall_gen (
        .mem_pending_i (mem_req_i && !done_mem),
        .stallreq_ex_i (stallreq_ex_i),
        .stallreq_id_i (stallreq_id_i),
        .if_pending_i  (if_req_i && !done_if),
        .stall_o       (stall_o)
    );

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: completions are checked against a
// scoreboard of expected responses queued when each request is issued.
module tb_mem_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, mem_we, bus_ack, stallreq_id, stallreq_ex;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, bus_req, bus_we, bus_err;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_arb_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_rdata_o    (if_rdata),
        .if_ready_o    (if_ready),
        .mem_req_i     (mem_req),
        .mem_we_i      (mem_we),
        .mem_addr_i    (mem_addr),
        .mem_wdata_i   (mem_wdata),
        .mem_sel_i     (mem_sel),
        .mem_rdata_o   (mem_rdata),
        .mem_ready_o   (mem_ready),
        .bus_req_o     (bus_req),
        .bus_we_o      (bus_we),
        .bus_addr_o    (bus_addr),
        .bus_wdata_o   (bus_wdata),
        .bus_sel_o     (bus_sel),
        .bus_ack_i     (bus_ack),
        .bus_rdata_i   (bus_rdata),
        .stallreq_id_i (stallreq_id),
        .stallreq_ex_i (stallreq_ex),
        .stall_o       (stall),
        .bus_err_o     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_mem, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rdata;
        e.err    = err;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every ready pulse pops and checks one expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (if_ready === 1'b1 || mem_ready === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check("sb_spurious_ready", {if_ready, mem_ready}, 2'b00);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ready_who", {if_ready, mem_ready}, {!e.is_mem, e.is_mem});
                check("sb_rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
                check("sb_bus_err", bus_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {if_req, mem_req, mem_we, bus_ack, stallreq_id, stallreq_ex} = '0;
        {if_addr, mem_addr, mem_wdata, bus_rdata} = '0;
        mem_sel = '0;

        // Reset state
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_stall", stall, 6'b000000);
        check("rst_ready", {if_ready, mem_ready, bus_err}, 3'b000);
        check("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
        check("rst_bus_addr", bus_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // IF-only fetch, ack on the 2nd access cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        push_exp(1'b0, 32'h2401_0005, 1'b0);
        #1 check("if_stall_idle", stall, 6'b000011);
        tick();
        check("if_bus_req", bus_req, 1);
        check("if_bus_addr", bus_addr, 32'h40);
        check("if_bus_we_sel", {bus_we, bus_sel}, 5'b0_1111);
        check("if_stall_acc", stall, 6'b000011);
        check("if_not_ready_early", if_ready, 0);
        tick();
        check("if_bus_req_c2", bus_req, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h2401_0005;
        tick();
        check("if_done_ready", if_ready, 1);
        check("if_done_bus_req", bus_req, 0);
        check("if_done_stall", stall, 6'b000000);
        check("if_done_rdata", if_rdata, 32'h2401_0005);
        if_req  = 1'b0;
        bus_ack = 1'b0;
        tick();
        check("if_ready_pulse", if_ready, 0);
        check("if_idle_stall", stall, 6'b000000);

        // Simultaneous store and fetch: MEM first, then IF
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0100;
        mem_wdata = 32'hDEAD_BEEF;
        mem_sel   = 4'b0011;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0044;
        push_exp(1'b1, 32'h1111_2222, 1'b0);
        push_exp(1'b0, 32'h3333_4444, 1'b0);
        #1 check("both_stall_idle", stall, 6'b011111);
        tick();
        check("both_mem_req", bus_req, 1);
        check("both_mem_we_sel", {bus_we, bus_sel}, 5'b1_0011);
        check("both_mem_addr", bus_addr, 32'h100);
        check("both_mem_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("both_mem_stall", stall, 6'b011111);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        check("both_mem_ready", mem_ready, 1);
        check("both_if_rdata_kept", if_rdata, 32'h2401_0005);
        check("both_done_stall", stall, 6'b000011);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        bus_ack = 1'b0;
        tick();
        check("both_idle_bus_req", bus_req, 0);
        check("both_idle_stall", stall, 6'b000011);
        tick();
        check("both_if_req", bus_req, 1);
        check("both_if_we_sel", {bus_we, bus_sel}, 5'b0_1111);
        check("both_if_addr", bus_addr, 32'h44);
        check("both_if_stall", stall, 6'b000011);
        bus_ack   = 1'b1;
        bus_rdata = 32'h3333_4444;
        tick();
        check("both_if_ready", if_ready, 1);
        check("both_mem_rdata_kept", mem_rdata, 32'h1111_2222);
        if_req  = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Hazard stall priority with no memory activity
        stallreq_id = 1'b1;
        stallreq_ex = 1'b1;
        #1 check("haz_ex_id", stall, 6'b001111);
        stallreq_ex = 1'b0;
        #1 check("haz_id", stall, 6'b000111);
        if_req = 1'b1;
        #1 check("haz_id_over_if", stall, 6'b000111);
        mem_req = 1'b1;
        stallreq_ex = 1'b1;
        #1 check("haz_mem_over_all", stall, 6'b011111);
        {if_req, mem_req, stallreq_id, stallreq_ex} = '0;
        #1 check("haz_clear", stall, 6'b000000);
        tick();
        check("haz_no_grant", bus_req, 0);

        // Timeout: no ack for MAX_WAIT access cycles
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0200;
        mem_sel  = 4'b1111;
        push_exp(1'b1, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 14; i++) begin
            check("to_wait_req", bus_req, 1);
            check("to_wait_err", bus_err, 0);
            tick();
        end
        check("to_last_cycle_req", bus_req, 1);
        tick();
        check("to_err", bus_err, 1);
        check("to_ready", mem_ready, 1);
        check("to_bus_req", bus_req, 0);
        check("to_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        tick();
        check("to_err_pulse", bus_err, 0);
        check("to_idle_bus_req", bus_req, 0);
        tick();

        // Ack in the same cycle the counter reaches MAX_WAIT
        mem_req  = 1'b1;
        mem_addr = 32'h0000_0300;
        push_exp(1'b1, 32'h5A5A_5A5A, 1'b0);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("late_req_held", bus_req, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h5A5A_5A5A;
        tick();
        check("late_ready", mem_ready, 1);
        check("late_no_err", bus_err, 0);
        check("late_rdata", mem_rdata, 32'h5A5A_5A5A);
        mem_req = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Reset asserted mid-access between clock edges
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h0000_0400;
        mem_wdata = 32'h0BAD_F00D;
        tick();
        check("rmid_req_before", bus_req, 1);
        #1 rst_n = 1'b0;
        #1 check("rmid_req_dropped", bus_req, 0);
        check("rmid_rdata_cleared", mem_rdata, 32'h0);
        #1 rst_n = 1'b1;
        #1 check("rmid_idle_stall", stall, 6'b011111);
        check("rmid_idle_req", bus_req, 0);
        push_exp(1'b1, 32'h7777_8888, 1'b0);
        tick();
        check("rmid_regrant", bus_req, 1);
        check("rmid_regrant_addr", bus_addr, 32'h400);
        check("rmid_regrant_we", bus_we, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_8888;
        tick();
        check("rmid_ready", mem_ready, 1);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        bus_ack = 1'b0;
        tick();
        tick();

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
